// File: rtl/rob_dispatch_if.sv
// Operand, multiplier and result signals of rob_dispatch.
// slave is the dispatcher side, master the surrounding logic.
interface rob_dispatch_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_multiplier;
  logic [7:0]    in_multiplicand;
  logic          mul_start;
  logic [7:0]    mul_multiplier;
  logic [7:0]    mul_multiplicand;
  logic [15:0]   mul_product;
  logic          mul_done;
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   out_product;
  logic          out_timeout;
  logic [CW-1:0] count;

  modport slave (
    input  in_valid, in_multiplier, in_multiplicand,
    input  mul_product, mul_done, out_ready,
    output in_ready, mul_start,
    output mul_multiplier, mul_multiplicand,
    output out_valid, out_product, out_timeout, count
  );

  modport master (
    output in_valid, in_multiplier, in_multiplicand,
    output mul_product, mul_done, out_ready,
    input  in_ready, mul_start,
    input  mul_multiplier, mul_multiplicand,
    input  out_valid, out_product, out_timeout, count
  );
endinterface

// File: rtl/rob_dispatch.sv
// Operand FIFO and sequencer around a Robertson multiplier.
// Guards stale done, times out hung ops, returns products in order.
module rob_dispatch #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          reset,
  rob_dispatch_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_GUARD,
    S_BUSY,
    S_HOLD
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   mem_q [DEPTH];
  logic [15:0]   mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [7:0]    mr_q, mr_d;
  logic [7:0]    md_q, md_d;
  logic          start_q, start_d;
  logic          ovalid_q, ovalid_d;
  logic [15:0]   oprod_q, oprod_d;
  logic          otmo_q, otmo_d;
  logic          in_ready;
  logic          push;
  logic          pop;

  // Full FIFO refuses input even if a pop lands in the same cycle.
  assign in_ready = (count_q < CW'(DEPTH));
  assign push     = bus.in_valid && in_ready;
  assign pop      = (state_q == S_IDLE) && (count_q != '0);

  assign bus.in_ready         = in_ready;
  assign bus.mul_start        = start_q;
  assign bus.mul_multiplier   = mr_q;
  assign bus.mul_multiplicand = md_q;
  assign bus.out_valid        = ovalid_q;
  assign bus.out_product      = oprod_q;
  assign bus.out_timeout      = otmo_q;
  assign bus.count            = count_q;

  // FIFO storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = {bus.in_multiplier, bus.in_multiplicand};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Sequencer: pop, pulse start, skip stale done, wait, hold result.
  always_comb begin
    state_d   = state_q;
    tmo_cnt_d = tmo_cnt_q;
    mr_d      = mr_q;
    md_d      = md_q;
    start_d   = 1'b0;
    ovalid_d  = ovalid_q;
    oprod_d   = oprod_q;
    otmo_d    = otmo_q;
    unique case (state_q)
      S_IDLE: begin
        if (pop) begin
          mr_d    = mem_q[rd_ptr_q][15:8];
          md_d    = mem_q[rd_ptr_q][7:0];
          start_d = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        state_d = S_GUARD;
      end
      S_GUARD: begin
        tmo_cnt_d = '0;
        state_d   = S_BUSY;
      end
      S_BUSY: begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        if (bus.mul_done) begin
          oprod_d  = bus.mul_product;
          otmo_d   = 1'b0;
          ovalid_d = 1'b1;
          state_d  = S_HOLD;
        end else if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
          oprod_d  = '0;
          otmo_d   = 1'b1;
          ovalid_d = 1'b1;
          state_d  = S_HOLD;
        end
      end
      S_HOLD: begin
        if (ovalid_q && bus.out_ready) begin
          ovalid_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // All state, cleared asynchronously so start drops at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      mem_q     <= '{default: '0};
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      tmo_cnt_q <= '0;
      mr_q      <= '0;
      md_q      <= '0;
      start_q   <= 1'b0;
      ovalid_q  <= 1'b0;
      oprod_q   <= '0;
      otmo_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      tmo_cnt_q <= tmo_cnt_d;
      mr_q      <= mr_d;
      md_q      <= md_d;
      start_q   <= start_d;
      ovalid_q  <= ovalid_d;
      oprod_q   <= oprod_d;
      otmo_q    <= otmo_d;
    end
  end
endmodule

// File: doc/rob_dispatch.md
# rob_dispatch

Operand dispatcher and result buffer that sits directly upstream and downstream of the `toprobertsons` signed 8×8 Robertson's multiplier. It accepts operand pairs on a valid/ready interface into a small FIFO and starts the multiplier for each pair. It waits for `done`, guards against a stale `done` and a hung multiplier, and presents each 16-bit signed product, in order, on a valid/ready output.

## Interface
Parameters:
- `DEPTH`, 4: operand FIFO entries (power of two, ≥2).
- `TIMEOUT`, 64: maximum BUSY cycles to wait for `mul_done` before abandoning an operation.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low; asserting (0) clears all state immediately.
- `in_valid` in 1: operand pair offered.
- `in_ready` out 1: FIFO can accept; `in_ready = (count < DEPTH)`.
- `in_multiplier` in 8: two's-complement multiplier.
- `in_multiplicand` in 8: two's-complement multiplicand.
- `mul_start` out 1: drives the multiplier's `reset` input; a one-cycle high pulse starts an operation.
- `mul_multiplier` out 8: operand to the multiplier, held stable from START through BUSY.
- `mul_multiplicand` out 8: operand to the multiplier, same timing.
- `mul_product` in 16: product from the multiplier.
- `mul_done` in 1: completion from the multiplier; it may still be high from the previous operation.
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer accepts the result.
- `out_product` out 16: signed product, or 0 on timeout.
- `out_timeout` out 1: result was abandoned after TIMEOUT cycles.
- `count` out $clog2(DEPTH)+1: FIFO occupancy.

## Operation
- FIFO:
  - Push when `in_valid && in_ready`; pop is performed only by the FSM in IDLE.
  - When full, `in_ready=0` even if a pop occurs in the same cycle; no push-through at full.
  - Simultaneous push and pop when not full leaves `count` unchanged.
  - Read and write pointers wrap modulo DEPTH.
- FSM states: IDLE, START, GUARD, BUSY, HOLD.
  - IDLE: if `count>0`, pop the head into the operand registers (`mul_multiplier/mul_multiplicand`), then go to START. Otherwise stay.
  - START: `mul_start=1` for exactly this cycle; go to GUARD.
  - GUARD: `mul_done` is ignored (it may be stale); go to BUSY and clear the timeout counter.
  - BUSY: each cycle, increment the counter.
    - If `mul_done=1`, capture `mul_product` into `out_product`, set `out_timeout=0`, `out_valid=1`, and go to HOLD.
    - Otherwise, if the counter reaches TIMEOUT-1, set `out_product=0`, `out_timeout=1`, `out_valid=1`, and go to HOLD.
    - `mul_done` takes priority when both conditions occur in the same cycle.
  - HOLD: on `out_valid && out_ready`, clear `out_valid` and go to IDLE. `out_product` and `out_timeout` hold until the next capture.
- Results leave in FIFO order; exactly one result per accepted pair; no result is dropped.
- No arithmetic is performed here; the product is passed through bit-exact (range −16256..16384).
- Reset values: state IDLE; `count=0` (so `in_ready=1`); `mul_start=0`; operand outputs 0; `out_valid=0`; `out_product=0`; `out_timeout=0`; pointers and counter 0.
- Reset mid-operation: all FIFO contents and any in-flight result are discarded, and `mul_start` drops immediately.

## Timing
- Push at edge k raises `count` after edge k. IDLE pops at edge k+1.
- START occupies cycle k+1..k+2 (`mul_start` high). GUARD occupies k+2..k+3. BUSY starts at k+3.
- If `mul_done` is sampled high at BUSY edge j, `out_valid` is high from edge j onward.
- After the handshake at edge h, the state is IDLE and the next pop occurs at edge h+1. Minimum spacing between successive `mul_start` pulses is 4 cycles plus multiplier latency.
- With `out_ready` tied high, HOLD lasts exactly one cycle.

## Test plan
- Single op: push (5, 6) with a real `toprobertsons` and `out_ready=1` → one `mul_start` pulse; `out_product=30`, `out_timeout=0`, one `out_valid` handshake.
- Fill and drain: `out_ready=0`, push (−5,6), (−9,−4), (7,−5), (127,−128) → `count=4`, `in_ready=0`, and a 5th push is refused. Raise `out_ready` → results −30, 36, −35, −16256 in order, and `in_ready` returns to 1.
- Stale done: stub multiplier holds `mul_done=1` from the previous op and drops it 1 cycle after `mul_start`, then re-asserts after 5 cycles with 0x1234 → `out_product=0x1234`, not the stale value.
- Timeout: stub never asserts `mul_done` → `out_valid` rises exactly 64 cycles after entering BUSY, with `out_product=0` and `out_timeout=1`. The next queued op proceeds normally.
- Reset mid-BUSY: assert `reset=0` asynchronously with 3 entries queued → `count`, `out_valid`, and `mul_start` go to 0 without a clock edge. After release, only newly pushed pairs produce results.
- Randomized: 10000 signed pairs with random `in_valid`/`out_ready` backpressure → every result equals the `$signed` product, in order, and the number of results equals the number of accepted pairs.
